// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit FND scan scheduler with blank phase, 16-step PWM and frame-aligned shadow load
// Optional FND_LZB_EN: leading-zero blanking of digits 3..1.
module fnd_scan_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        enable,
  input  logic [15:0] digit_val,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  brightness,
  input  logic        load_req,
  output logic        load_ack,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_seg,
  output logic        frame_done
);

  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int STEP_CYC = SLOT_CYC / 16;
  localparam int LAST_CYC = SLOT_CYC - 15 * STEP_CYC;
  localparam int CYC_W    = $clog2(LAST_CYC + 1);
  localparam logic [CYC_W-1:0] STEP_M1 = CYC_W'(STEP_CYC - 1);
  localparam logic [CYC_W-1:0] LAST_M1 = CYC_W'(LAST_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON, S_OFF} state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, step_last;
  logic [3:0]       step_q, step_d;
  logic [1:0]       dig_q, dig_d;
  logic [15:0]      val_q;
  logic [3:0]       dp_q, br_q;
  logic [3:0]       com_q, com_d;
  logic [7:0]       seg_q, seg_d;
  logic             ack_q, ack_d, fd_q, fd_d;
  logic [3:0]       nib;
  logic [6:0]       seg7;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;  4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;  4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;  4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;  4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;  4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;  default: hex2seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    step_d    = step_q;
    dig_d     = dig_q;
    step_last = (step_q == 4'd15) ? LAST_M1 : STEP_M1;
    if (!enable) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      step_d  = '0;
      dig_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_BLANK;
      cyc_d   = '0;
      step_d  = '0;
      dig_d   = '0;
    end else if (cyc_q == step_last) begin
      cyc_d  = '0;
      step_d = step_q + 4'd1;
      if (step_q == 4'd15) begin
        dig_d   = dig_q + 2'd1;
        state_d = S_BLANK;
      end else if (step_d <= br_q) begin
        state_d = S_ON;
      end else begin
        state_d = S_OFF;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end

    // Outputs are registered from the next position, so they align with the state register.
    fd_d  = (state_d != S_IDLE) && (dig_d == 2'd3) && (step_d == 4'd15) && (cyc_d == LAST_M1);
    ack_d = (fd_d && load_req) || ((state_q == S_IDLE) && load_req && !ack_q);

    nib  = val_q[{dig_d, 2'b00} +: 4];
    seg7 = hex2seg(nib);
`ifdef FND_LZB_EN
    if ((dig_d != 2'd0) && ((val_q >> {dig_d, 2'b00}) == 16'd0))
      seg7 = 7'h7F;
`endif
    com_d = (state_d == S_ON) ? ~(4'b0001 << dig_d) : 4'hF;
    seg_d = (state_d == S_ON) ? {~dp_q[dig_d], seg7} : 8'hFF;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      step_q  <= '0;
      dig_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      br_q    <= '0;
      com_q   <= 4'hF;
      seg_q   <= 8'hFF;
      ack_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      step_q  <= step_d;
      dig_q   <= dig_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
      ack_q   <= ack_d;
      fd_q    <= fd_d;
      // Shadows change only after this cycle's display was computed from the old values.
      if (ack_d) begin
        val_q <= digit_val;
        dp_q  <= dp_mask;
        br_q  <= brightness;
      end
    end
  end

  assign fnd_com    = com_q;
  assign fnd_seg    = seg_q;
  assign load_ack   = ack_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - self-checking bench for fnd_scan_ctrl with a frame-position reference model
module tb_fnd_scan_ctrl;

  localparam int SLOT  = 1600;
  localparam int STEP  = 100;
  localparam int FRAME = 4 * SLOT;
`ifdef FND_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digit_val = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  brightness = '0;
  logic        load_req = 1'b0;
  logic        load_ack, frame_done;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_seg;

  int n_tests = 0;
  int n_fail  = 0;

  fnd_scan_ctrl #(.CLK_HZ(1_600_000), .SCAN_HZ(1000)) dut (
    .ACLK(clk), .ARESET(rst), .enable(enable), .digit_val(digit_val),
    .dp_mask(dp_mask), .brightness(brightness), .load_req(load_req),
    .load_ack(load_ack), .fnd_com(fnd_com), .fnd_seg(fnd_seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: display is a pure function of position p within the frame and the shadows.
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_run;
  int          m_p, m_d, m_st;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_br, m_nib;
  logic [6:0]  m_s7;
  logic        m_cap;
  logic        exp_ack, exp_fd;
  logic [3:0]  exp_com;
  logic [7:0]  exp_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_p = 0; m_val = '0; m_dp = '0; m_br = '0;
      exp_ack = 0; exp_fd = 0; exp_com = 4'hF; exp_seg = 8'hFF;
    end else begin
      m_cap  = 1'b0;
      exp_fd = 1'b0;
      if (!m_run) begin
        m_cap = load_req && !exp_ack;
        if (enable) begin m_run = 1; m_p = 0; end
      end else if (!enable) begin
        m_run = 0;
      end else begin
        m_p = (m_p + 1) % FRAME;
        if (m_p == FRAME - 1) begin exp_fd = 1'b1; m_cap = load_req; end
      end
      exp_ack = m_cap;
      exp_com = 4'hF;
      exp_seg = 8'hFF;
      if (m_run) begin
        m_d  = m_p / SLOT;
        m_st = (m_p % SLOT) / STEP;
        if (m_st > 15) m_st = 15;
        if (m_st >= 1 && m_st <= int'(m_br)) begin
          m_nib = 4'((m_val >> (4 * m_d)) & 16'hF);
          m_s7  = dec_tab[m_nib];
          if (LZB && m_d > 0 && (m_val >> (4 * m_d)) == 0) m_s7 = 7'h7F;
          exp_com = ~(4'b0001 << m_d);
          exp_seg = {~m_dp[m_d], m_s7};
        end
      end
      if (m_cap) begin m_val = digit_val; m_dp = dp_mask; m_br = brightness; end
    end
  end

  always @(negedge clk) begin
    chk("cyc_com", {28'd0, fnd_com}, {28'd0, exp_com});
    chk("cyc_seg", {24'd0, fnd_seg}, {24'd0, exp_seg});
    chk("cyc_frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    chk("cyc_load_ack", {31'd0, load_ack}, {31'd0, exp_ack});
  end

  int         on_cnt [4];
  int         first_idx [4];
  logic [3:0] first_com [4];
  logic [7:0] first_seg [4];
  int         fd_cnt, bad_com;

  task automatic watch(input int n);
    int d;
    for (int j = 0; j < 4; j++) begin on_cnt[j] = 0; first_idx[j] = 0; first_com[j] = 4'hF; first_seg[j] = 8'hFF; end
    fd_cnt = 0; bad_com = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (fnd_com != 4'hF) begin
        case (fnd_com)
          4'hE: d = 0;
          4'hD: d = 1;
          4'hB: d = 2;
          4'h7: d = 3;
          default: d = -1;
        endcase
        if (d < 0) bad_com++;
        else begin
          on_cnt[d]++;
          if (first_idx[d] == 0) begin first_idx[d] = i; first_com[d] = fnd_com; first_seg[d] = fnd_seg; end
        end
      end
    end
    chk("bad_com", bad_com, 0);
  endtask

  task automatic wait_ack(input int limit, output int k, output logic fd_at);
    k = 0;
    do begin @(negedge clk); k++; end while (!load_ack && k < limit);
    chk("ack_seen", {31'd0, load_ack}, 1);
    fd_at = frame_done;
  endtask

  task automatic idle_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] br);
    int   k;
    logic f;
    digit_val = v; dp_mask = dp; brightness = br; load_req = 1'b1;
    wait_ack(10, k, f);
    chk("idle_ack_latency", k, 1);
    load_req = 1'b0;
  endtask

  initial begin
    int   k;
    logic f;
    repeat (3) @(negedge clk);
    chk("rst_com", {28'd0, fnd_com}, 32'hF);
    chk("rst_seg", {24'd0, fnd_seg}, 32'hFF);
    chk("rst_ack", {31'd0, load_ack}, 0);
    chk("rst_fd", {31'd0, frame_done}, 0);
    rst = 1'b0;
    watch(20);
    chk("idle_dark", on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3], 0);
    chk("idle_no_fd", fd_cnt, 0);

    idle_load(16'h1234, 4'h0, 4'hF);
    enable = 1'b1;
    watch(6401);
    chk("first_on_latency", first_idx[0], 101);
    chk("d1_start", first_idx[1], 1701);
    chk("d0_com", {28'd0, first_com[0]}, 32'hE);
    chk("d0_seg", {24'd0, first_seg[0]}, 32'h99);
    chk("d1_com", {28'd0, first_com[1]}, 32'hD);
    chk("d1_seg", {24'd0, first_seg[1]}, 32'hB0);
    chk("d2_com", {28'd0, first_com[2]}, 32'hB);
    chk("d2_seg", {24'd0, first_seg[2]}, 32'hA4);
    chk("d3_com", {28'd0, first_com[3]}, 32'h7);
    chk("d3_seg", {24'd0, first_seg[3]}, 32'hF9);
    for (int j = 0; j < 4; j++) chk("on_1500", on_cnt[j], 1500);
    chk("fd_once", fd_cnt, 1);

    watch(3000);
    digit_val = 16'hABCD; brightness = 4'h4; dp_mask = 4'h0; load_req = 1'b1;
    wait_ack(7000, k, f);
    chk("ack_at_frame_end", k, 3399);
    chk("ack_with_fd", {31'd0, f}, 1);
    watch(1600);
    chk("br4_on", on_cnt[0], 400);
    chk("br4_start", first_idx[0], 101);
    chk("abcd_d0_seg", {24'd0, first_seg[0]}, 32'hA1);
    wait_ack(7000, k, f);
    chk("second_ack_gap", 1600 + k, FRAME);
    chk("second_ack_fd", {31'd0, f}, 1);
    load_req = 1'b0;

    watch(2000);
    chk("mid_com", {28'd0, fnd_com}, 32'hD);
    chk("mid_seg", {24'd0, fnd_seg}, 32'hC6);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_com", {28'd0, fnd_com}, 32'hF);
    chk("drop_seg", {24'd0, fnd_seg}, 32'hFF);
    watch(50);
    chk("drop_dark", on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3], 0);
    enable = 1'b1;
    watch(101);
    chk("restart_idx", first_idx[0], 101);
    chk("restart_com", {28'd0, first_com[0]}, 32'hE);

    enable = 1'b0;
    @(negedge clk);
    idle_load(16'h0070, 4'h0, 4'h0);
    enable = 1'b1;
    watch(6400);
    chk("br0_dark", on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3], 0);
    chk("br0_fd", fd_cnt, 1);

    enable = 1'b0;
    @(negedge clk);
    idle_load(16'h0070, 4'b0101, 4'hF);
    enable = 1'b1;
    watch(6401);
    chk("lz_d3", {24'd0, first_seg[3]}, LZB ? 32'hFF : 32'hC0);
    chk("lz_d2", {24'd0, first_seg[2]}, LZB ? 32'h7F : 32'h40);
    chk("lz_d1", {24'd0, first_seg[1]}, 32'hF8);
    chk("lz_d0", {24'd0, first_seg[0]}, 32'h40);
    chk("lz_d3_on", on_cnt[3], 1500);

    watch(150);
    chk("pre_rst_com", {28'd0, fnd_com}, 32'hE);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_com", {28'd0, fnd_com}, 32'hF);
    chk("async_rst_seg", {24'd0, fnd_seg}, 32'hFF);
    chk("async_rst_ack", {31'd0, load_ack}, 0);
    @(negedge clk);
    rst = 1'b0;
    watch(20);
    chk("post_rst_dark", on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexing scan scheduler for the external 4-digit FND (7-segment) display behind the EXTERNAL_FND_CNTR AXI4-Lite slave. It shares the single segment bus among four common-anode digits, with an anti-ghosting blank phase and 16-step PWM brightness. Register-side values from the AXI slave are transferred into shadow registers only at frame boundaries, under a req/ack handshake, so the display never shows a torn value.

## Interface
- CLK_HZ, 100_000_000, ACLK frequency in Hz
- SCAN_HZ, 1000, per-digit slot rate; SLOT_CYC = CLK_HZ/SCAN_HZ, STEP_CYC = SLOT_CYC/16 (integer division; leftover cycles are appended to step 15)
- ACLK  in  1  clock
- ARESET  in  1  reset; one clock domain; reset is asynchronous and active-high
- enable  in  1  scan enable (level)
- digit_val  in  16  four hex nibbles; [3:0] = digit 0 (rightmost)
- dp_mask  in  4  decimal point per digit, 1 = lit
- brightness  in  4  duty in 16ths; 0 = dark
- load_req  in  1  request to capture digit_val/dp_mask/brightness
- load_ack  out  1  one-cycle pulse: shadows captured this cycle
- fnd_com  out  4  digit commons, active-low, bit n = digit n
- fnd_seg  out  8  active-low segments; [6:0] = g..a, [7] = dp
- frame_done  out  1  one-cycle pulse at the end of digit-3 slot

## Operation
- Slot order is digit 0,1,2,3, then repeat. Each slot has 16 steps.
- Step 0 is BLANK: fnd_com = 4'hF and fnd_seg = 8'hFF.
- Steps 1..15: ON while step <= shadow brightness, otherwise OFF (com 4'hF, seg 8'hFF).
- Duty is therefore brightness/16, with a maximum of 15/16.
- FSM states:
  - IDLE: enable = 0, all outputs dark.
  - BLANK: step 0.
  - ON: current digit driven.
  - OFF: dimmed remainder of the slot.
- FSM transitions:
  - IDLE → BLANK when enable rises.
  - BLANK → ON or OFF at the end of step 0.
  - ON → OFF when step exceeds brightness.
  - ON/OFF → BLANK at slot end, advancing the digit index (3 wraps to 0).
- Decoder, hex to active-low seg[6:0]:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
  - seg[7] = ~dp_mask[n].
- Load handshake:
  - load_req is a level. Inputs must stay stable while it is high.
  - Capture and a load_ack pulse occur on the last cycle of a frame (the same cycle as frame_done).
  - When in IDLE, capture and ack occur on the first cycle load_req is seen high.
  - The requester drops load_req the cycle after ack. If it is still high at the next frame end, a second capture occurs (legal).
- Simultaneous events:
  - load_req rising on the frame's last cycle is captured at that boundary.
  - enable falling on the frame's last cycle: frame_done and the capture still occur, then the FSM goes to IDLE.
- enable deasserted mid-frame: the next cycle goes to IDLE. The step, slot and digit counters are cleared, and the shadows are kept.

## Timing
- All outputs are registered.
- fnd_com and fnd_seg change in the same cycle: one cycle after the internal step/slot counter boundary.
- Latency from enable rising to the first digit-0 ON state: 1 + STEP_CYC cycles (IDLE → BLANK register, then step 0).
- The frame lasts 4·SLOT_CYC cycles. frame_done and load_ack are high for exactly 1 cycle.
- New shadow values take effect starting with the digit-0 slot that follows the ack.
- Reset values: fnd_com = 4'hF, fnd_seg = 8'hFF, load_ack = 0, frame_done = 0. The FSM is in IDLE. Shadows are digit 0000, dp 0, brightness 0.
- ARESET asserted mid-operation clears everything asynchronously. A pending load is dropped, and the requester must re-see an ack.

## Configuration
- FND_LZB_EN defined: leading-zero blanking. Digits 3..1 whose nibble is 0, and all of whose higher digits are also 0, show seg[6:0] = 7F. Their dp is still driven per dp_mask. Digit 0 is never blanked.
- FND_LZB_EN undefined: every digit always shows its decoded nibble.

## Test plan
Use CLK_HZ = 1_600_000, SCAN_HZ = 1000, giving SLOT_CYC = 1600 and STEP_CYC = 100.
- Reset: assert ARESET, then release with enable = 0. Required: fnd_com = F and fnd_seg = FF, held indefinitely; load_ack = 0.
- Basic scan: load 16'h1234, brightness F, dp 0000, enable = 1. Required:
  - Digit 0 ON: com = E, seg = 99.
  - Then com = D/seg = B0, com = B/seg = A4, com = 7/seg = F9.
  - Each digit has 1500 ON cycles preceded by 100 blank cycles.
  - frame_done pulses every 6400 cycles.
- Brightness: brightness 4. Required: per slot, 100 blank + 400 ON + 1100 dark cycles. Brightness 0 gives dark for the whole slot.
- Handshake: raise load_req with 16'hABCD mid-frame. Required:
  - No display change until the frame end.
  - load_ack coincides with frame_done.
  - The next digit-0 slot shows seg = A1 (d).
  - Holding load_req one extra frame produces a second ack.
- Boundaries:
  - Drop enable mid-slot: outputs are dark in the next cycle, and re-enable restarts at digit 0.
  - Assert ARESET during an ON step: outputs are FF asynchronously.
- FND_LZB_EN: load 16'h0070. Required:
  - Defined: digit 3 and digit 2 show seg = FF, digit 1 shows F8, digit 0 shows C0.
  - Undefined: digits 3 and 2 show C0.
